// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a loadable pattern, overlap control and a saturating match counter.
// Define SEQDET_MASK_EN to add a per-bit don't-care mask (port pat_mask_in).
module seq_pattern_detector #(
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic             w_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  cmp_mask;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              match;

`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0] mask_reg;

  always_ff @(posedge clk) begin
    if (reset)
      mask_reg <= '1;
    else if (pat_load)
      mask_reg <= pat_mask_in;
  end

  assign cmp_mask = mask_reg;
`else
  assign cmp_mask = '1;
`endif

  // Match is judged on the post-shift view, so z can be registered straight from it.
  always_comb begin
    hist_shift = {history[PAT_W-2:0], w};
    fill_inc   = (fill == FILL_FULL) ? fill : fill + 1'b1;
    match      = w_valid && !pat_load && (fill_inc == FILL_FULL) &&
                 (((hist_shift ^ pattern) & cmp_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      history     <= '0;
      fill        <= '0;
      pattern     <= PAT_RESET;
      z           <= 1'b0;
      match_count <= '0;
    end else begin
      z <= match;
      if (pat_load) begin
        pattern <= pat_in;
        history <= '0;
        fill    <= '0;
      end else if (w_valid) begin
        history <= hist_shift;
        fill    <= (match && !overlap_en) ? '0 : fill_inc;
      end
      // Clear beats a coincident match; the counter never wraps.
      if (cnt_clr)
        match_count <= '0;
      else if (match && (match_count != CNT_MAX))
        match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed scoreboard bench for seq_pattern_detector (PAT_W=4, CNT_W=2).
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       w = 1'b0;
  logic       w_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic [3:0] pat_mask_in = 4'b1111;
  logic       overlap_en = 1'b1;
  logic       cnt_clr = 1'b0;
  logic       z;
  logic [1:0] match_count;

  seq_pattern_detector #(.PAT_W(4), .CNT_W(2), .PAT_RESET(4'b1011)) dut (
    .clk(clk),
    .reset(reset),
    .w(w),
    .w_valid(w_valid),
    .pat_load(pat_load),
    .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .overlap_en(overlap_en),
    .cnt_clr(cnt_clr),
    .z(z),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       z;
    bit [1:0] cnt;
    string    tag;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;

  // Reference model: the accepted bits since the last restart, oldest first.
  bit       mbits[$];
  bit [3:0] mpat = 4'b1011;
  bit [3:0] mmask = 4'b1111;
  bit [1:0] mcnt = 2'd0;

  task automatic checkOutput();
    exp_t e;
    if (expq.size() == 0) return;
    e = expq.pop_front();
    if (z === 1'b1) pulses++;
    checks++;
    assert (z === e.z) else begin
      errors++;
      $error("[TB] FAIL %s z: observed=%b expected=%b", e.tag, z, e.z);
    end
    checks++;
    assert (match_count === e.cnt) else begin
      errors++;
      $error("[TB] FAIL %s count: observed=%0d expected=%0d", e.tag, match_count, e.cnt);
    end
  endtask

  task automatic applyStimulus(input string tag, input bit rst, input bit vld, input bit wb,
                               input bit load, input bit [3:0] pin, input bit [3:0] pmask,
                               input bit ov, input bit clr);
    exp_t     e;
    bit [3:0] h;
    @(negedge clk);
    checkOutput();
    reset = rst; w_valid = vld; w = wb; pat_load = load;
    pat_in = pin; pat_mask_in = pmask; overlap_en = ov; cnt_clr = clr;
    e.z = 1'b0;
    e.tag = tag;
    if (rst) begin
      mbits.delete();
      mcnt = 2'd0;
      mpat = 4'b1011;
      mmask = 4'b1111;
    end else begin
      if (load) begin
        mpat = pin;
`ifdef SEQDET_MASK_EN
        mmask = pmask;
`endif
        mbits.delete();
      end else if (vld) begin
        mbits.push_back(wb);
        if (mbits.size() > 4) void'(mbits.pop_front());
        if (mbits.size() == 4) begin
          h = {mbits[0], mbits[1], mbits[2], mbits[3]};
          if (((h ^ mpat) & mmask) == 4'b0000) begin
            e.z = 1'b1;
            if (!ov) mbits.delete();
          end
        end
      end
      if (clr) mcnt = 2'd0;
      else if (e.z && mcnt != 2'd3) mcnt = mcnt + 2'd1;
    end
    e.cnt = mcnt;
    expq.push_back(e);
  endtask

  task automatic doReset();
    applyStimulus("reset", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
  endtask

  task automatic sendBits(input string tag, input bit [15:0] bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--)
      applyStimulus(tag, 1'b0, 1'b1, bits[i], 1'b0, 4'b0000, 4'b1111, ov, 1'b0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(tag, 1'b0, 1'b0, i[0], 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
  endtask

  // Pulse totals are compared against the figures the scenario is meant to produce.
  task automatic checkPulses(input string tag, input int want);
    checks++;
    assert (pulses == want) else begin
      errors++;
      $error("[TB] FAIL %s pulses: observed=%0d expected=%0d", tag, pulses, want);
    end
    pulses = 0;
  endtask

  initial begin
    doReset();
    doReset();
    idle("reset_hold", 1);
    pulses = 0;

    sendBits("basic", 16'b1011, 4, 1'b1);
    idle("basic_tail", 2);
    checkPulses("basic", 1);

    doReset();
    sendBits("ovl_on", 16'b1011011, 7, 1'b1);
    idle("ovl_on_tail", 1);
    checkPulses("ovl_on", 2);

    doReset();
    sendBits("ovl_off", 16'b1011011, 7, 1'b0);
    idle("ovl_off_tail", 1);
    checkPulses("ovl_off", 1);

    doReset();
    sendBits("gap_a", 16'b10, 2, 1'b1);
    idle("gap", 3);
    sendBits("gap_b", 16'b11, 2, 1'b1);
    idle("gap_tail", 1);
    checkPulses("gap", 1);

    doReset();
    sendBits("load_pre", 16'b101, 3, 1'b1);
    applyStimulus("load", 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 4'b1111, 1'b1, 1'b0);
    sendBits("load_post", 16'b10110, 5, 1'b1);
    idle("load_tail", 1);
    checkPulses("load", 1);

    doReset();
    sendBits("sat", 16'b1011_1011_1011_1011, 16, 1'b0);
    sendBits("sat5", 16'b1011, 4, 1'b0);
    sendBits("clr6", 16'b101, 3, 1'b0);
    applyStimulus("clr6_last", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1);
    idle("clr_tail", 1);
    checkPulses("sat_clr", 6);

    doReset();
    sendBits("rst_mid", 16'b101, 3, 1'b1);
    applyStimulus("rst_prio", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1);
    sendBits("rst_after", 16'b1, 1, 1'b1);
    idle("rst_tail", 1);
    checkPulses("rst_mid", 0);

`ifdef SEQDET_MASK_EN
    doReset();
    applyStimulus("mask_load", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 4'b1001, 1'b0, 1'b0);
    sendBits("mask", 16'b1001_1111_0111, 12, 1'b0);
    idle("mask_tail", 1);
    checkPulses("mask", 2);
`endif

    @(negedge clk);
    checkOutput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
